// File: rtl/mdu_pkg.sv
// mdu_pkg: md_op encodings, default MDU latencies and the MDU FSM state type
package mdu_pkg;
  typedef enum logic [2:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_RSVD
  } md_op_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle mult/div unit with HI/LO (in: clk, reset_n, E_A, E_B, md_op, start, req; out: HI, LO, busy)
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [2:0]  md_op,
  input  logic        start,
  input  logic        req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy
);
  state_e state, state_d;
  logic [3:0] cnt, cnt_d;
  md_op_e op_q;
  logic [31:0] a_q, b_q, ua, ub, ubz, q, r, quo, rem;
  logic [63:0] xa, xb, prod;
  logic free, accept, mul_in, done, mul, sd, neg_a, neg_b, wr;
  assign busy = state == RUN;
  assign free = ~req & ~busy;
  assign mul_in = md_op == MD_MULT || md_op == MD_MULTU;
  assign accept = free & start & (mul_in || md_op == MD_DIV || md_op == MD_DIVU);
  assign done = busy && cnt == 4'd1;
  assign mul = op_q == MD_MULT || op_q == MD_MULTU;
  always_comb begin
    xa = {{32{op_q == MD_MULT && a_q[31]}}, a_q};
    xb = {{32{op_q == MD_MULT && b_q[31]}}, b_q};
    prod = xa * xb;
    sd = op_q == MD_DIV;
    neg_a = sd & a_q[31];
    neg_b = sd & b_q[31];
    ua = neg_a ? -a_q : a_q;
    ub = neg_b ? -b_q : b_q;
    ubz = ub == 32'd0 ? 32'd1 : ub;
    q = ua / ubz;
    r = ua % ubz;
    quo = neg_a ^ neg_b ? -q : q;
    rem = neg_a ? -r : r;
    wr = done && (mul || b_q != 32'd0);
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    if (busy) begin
      cnt_d = cnt - 4'd1;
      state_d = cnt == 4'd1 ? IDLE : RUN;
    end else if (accept) begin
      cnt_d = mul_in ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      state_d = RUN;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= MD_NONE;
      a_q <= '0;
      b_q <= '0;
      HI <= '0;
      LO <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (accept) begin
        op_q <= md_op_e'(md_op);
        a_q <= E_A;
        b_q <= E_B;
      end
      if (wr) {HI, LO} <= mul ? prod : {rem, quo};
      if (free && md_op == MD_MTHI) HI <= E_A;
      if (free && md_op == MD_MTLO) LO <= E_A;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed table-driven and sequence checks for mdu
module tb_mdu;
  import mdu_pkg::*;
  logic clk = 0, reset_n = 0, start = 0, req = 0;
  logic [31:0] E_A = 0, E_B = 0, HI, LO;
  logic [2:0] md_op = 0;
  logic busy;
  int checks = 0, errors = 0;
  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b;
    int n;
    logic [31:0] hi, lo;
  } vec_t;
  vec_t v[9];
  mdu dut (
    .clk(clk), .reset_n(reset_n), .E_A(E_A), .E_B(E_B), .md_op(md_op),
    .start(start), .req(req), .HI(HI), .LO(LO), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, b,
                        input int n, input logic [31:0] hi, lo);
    int cyc;
    md_op = op; E_A = a; E_B = b; start = 1; req = 0;
    chk({name, " accept_busy"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 0; md_op = MD_NONE; E_A = $urandom; E_B = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, cyc, n);
    chk({name, " HI"}, HI, hi);
    chk({name, " LO"}, LO, lo);
  endtask
  task automatic mt(input logic [2:0] op, input logic [31:0] val, input logic r);
    md_op = op; E_A = val; req = r;
    @(negedge clk);
    md_op = MD_NONE; req = 0;
  endtask
  initial begin
    int cyc, seen;
    v[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    v[1] = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
    v[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[3] = '{MD_DIVU,  32'hFFFFFFF9, 32'd2,        10, 32'h00000001, 32'h7FFFFFFC};
    v[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    v[5] = '{MD_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
    v[6] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    v[7] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    v[8] = '{MD_DIV,   32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
    #1;
    chk("reset HI", HI, 0);
    chk("reset LO", LO, 0);
    chk("reset busy", {31'd0, busy}, 0);
    @(negedge clk);
    reset_n = 1;
    foreach (v[i]) run_op($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].n, v[i].hi, v[i].lo);
    mt(MD_MTHI, 32'h11, 0);
    chk("mthi HI", HI, 32'h11);
    mt(MD_MTLO, 32'h22, 0);
    chk("mtlo LO", LO, 32'h22);
    run_op("divu_by_zero", MD_DIVU, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    mt(MD_MTHI, 32'h1234, 1);
    chk("mthi_req HI", HI, 32'h11);
    mt(MD_MTHI, 32'h1234, 0);
    chk("mthi_noreq HI", HI, 32'h1234);
    chk("mthi busy", {31'd0, busy}, 0);
    md_op = MD_MULT; E_A = 3; E_B = 3; start = 1; req = 1;
    @(negedge clk);
    chk("mult_req busy", {31'd0, busy}, 0);
    req = 0; start = 0;
    @(negedge clk);
    chk("mult_nostart busy", {31'd0, busy}, 0);
    chk("mult_cancel LO", LO, 32'h22);
    md_op = MD_MULT; E_A = 32'hFFFFFFFE; E_B = 3; start = 1;
    @(negedge clk);
    start = 0; md_op = MD_NONE;
    @(negedge clk);
    md_op = MD_MTLO; E_A = 32'hDEAD;
    @(negedge clk);
    md_op = MD_MULT; E_A = 7; E_B = 7; start = 1;
    @(negedge clk);
    md_op = MD_NONE; start = 0;
    cyc = 3;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk("busy_ignore busy_cycles", cyc, 5);
    chk("busy_ignore LO", LO, 32'hFFFFFFFA);
    chk("busy_ignore HI", HI, 32'hFFFFFFFF);
    @(negedge clk);
    chk("busy_ignore no_restart", {31'd0, busy}, 0);
    md_op = MD_DIV; E_A = 32'd100; E_B = 32'd7; start = 1;
    @(negedge clk);
    md_op = MD_NONE; start = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("midreset HI", HI, 0);
    chk("midreset LO", LO, 0);
    chk("midreset busy", {31'd0, busy}, 0);
    @(negedge clk);
    reset_n = 1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || HI !== 0 || LO !== 0) seen++;
    end
    chk("midreset no_write", seen, 0);
    run_op("post_reset", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 E_A  in  32  forwarded rs operand (E-stage ALU A value).
REQ-006 E_B  in  32  forwarded rt operand (E-stage next-B value).
REQ-007 md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-008 start  in  1  qualifies md_op 1..4 as a new operation this cycle.
REQ-009 req  in  1  exception/interrupt request; cancels acceptance of any op this cycle.
REQ-010 HI  out  32  HI register, feeds E-stage ALU-B select code 2.
REQ-011 LO  out  32  LO register, feeds E-stage ALU-B select code 3.
REQ-012 busy  out  1  operation in flight; consumed by hazard unit for stall.

Function
REQ-013 States IDLE and RUN only; counter cnt, 4 bits, down-counting.
REQ-014 Accept = start & ~req & ~busy & md_op in 1..4; on accept, operands and op latched, cnt loaded with MULT_CYCLES or DIV_CYCLES, state -> RUN.
REQ-015 busy SHALL be 1 exactly for the N cycles after the accept edge (N = loaded count), 0 otherwise; busy is not asserted in the accept cycle itself.
REQ-016 In RUN cnt decrements each edge; on the edge where cnt goes 1 -> 0, HI/LO are written with the result and state -> IDLE.
REQ-017 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-018 div: LO = quotient truncated toward zero, HI = remainder with sign of dividend (E_A); divu unsigned.
REQ-019 Signed overflow case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-020 Divisor zero (div or divu): HI and LO unchanged at completion; busy timing unchanged.
REQ-021 mthi/mtlo with ~req & ~busy: HI (resp. LO) = E_A on next edge, no busy; start not required.
REQ-022 Any op (including mthi/mtlo) presented while busy=1 SHALL be ignored; in-flight op unaffected.
REQ-023 req=1 cancels only the op presented that cycle; an op already in RUN completes normally.
REQ-024 Result computed from latched operands; E_A/E_B changes after accept have no effect.
REQ-025 Back-to-back: new op accepted in the cycle busy first returns 0.

Reset
REQ-026 reset_n=0 asynchronously forces HI=0, LO=0, busy=0, cnt=0, state IDLE, regardless of clk.
REQ-027 Reset mid-operation discards the in-flight result; no HI/LO write after release.
REQ-028 First accept possible on first rising edge after reset_n deasserts.

Structure
REQ-029 Shared package holds md_op encodings (MD_NONE..MD_MTLO) and default MULT_CYCLES/DIV_CYCLES constants, shared with controller and hazard unit.
REQ-030 No sub-module; product/quotient computed combinationally from latched operands inside mdu, registered only into HI/LO.

Verification
REQ-031 mult E_A=0xFFFFFFFE, E_B=3, start -> busy 1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 div E_A=0xFFFFFFF9 (-7), E_B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu same operands -> LO=0x7FFFFFFC, HI=1.
REQ-033 div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; divu 5/0 with prior HI=0x11,LO=0x22 -> HI/LO remain 0x11/0x22.
REQ-034 mthi E_A=0x1234 with req=1 -> HI unchanged; same with req=0 -> HI=0x1234 next edge, busy stays 0.
REQ-035 mult accepted, mtlo presented at busy cycle 2 -> mtlo ignored, LO = product at completion.
REQ-036 reset_n pulsed low during busy cycle 3 of div -> HI=LO=0, busy=0 immediately, no later write.
